// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between the fetch and decode stages.
// Each accepted fetch word is tagged with a sequence number. The tag
// increments by one per accepted word and wraps modulo 2^SEQ_W. Decode sees
// the oldest entry through a valid/ready handshake. Fetch is stalled while
// the queue is full. A flush empties the queue in one cycle.
//
// Ports
//   in_clk          clock, rising edge
//   in_rst_n        asynchronous active-low reset
//   in_f_insnbits   instruction word from fetch (sampled when in_f_done=1)
//   in_f_done       enqueue request from fetch
//   out_f_stall     queue full; fetch must hold its PC
//   in_flush        drop all buffered and incoming instructions
//   in_d_ready      decode accepts the head entry this cycle
//   out_d_valid     head entry valid
//   out_d_insnbits  head instruction word, 0 when empty
//   out_d_seq       head sequence tag, 0 when empty
//   out_count       current occupancy
//   out_overflow    sticky: an enqueue was dropped because the queue was full
//
// DEPTH must be a power of two and at least 2. The pointers then wrap
// modulo DEPTH through plain binary overflow.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic [31:0]              in_f_insnbits,
  input  logic                     in_f_done,
  output logic                     out_f_stall,
  input  logic                     in_flush,
  input  logic                     in_d_ready,
  output logic                     out_d_valid,
  output logic [31:0]              out_d_insnbits,
  output logic [SEQ_W-1:0]         out_d_seq,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]      insn_mem [DEPTH];
  logic [SEQ_W-1:0] seq_mem  [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;

  logic full, valid, deq, enq_req, enq;

  // All outputs come from registered state only.
  assign full        = (count_q == CntW'(DEPTH));
  assign valid       = (count_q != '0);
  assign out_f_stall = full;
  assign out_d_valid = valid;
  assign out_count   = count_q;
  assign out_overflow = ovf_q;
  assign out_d_insnbits = valid ? insn_mem[rd_ptr_q] : '0;
  assign out_d_seq      = valid ? seq_mem[rd_ptr_q]  : '0;

  assign deq     = valid & in_d_ready & ~in_flush;
  assign enq_req = in_f_done & ~in_flush;
  // A push into a full queue is taken only if the head leaves in the same cycle.
  assign enq     = enq_req & (~full | deq);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    if (in_flush) begin
      // Tags keep counting across a flush so younger work never reuses a tag.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        seq_d    = seq_q + SEQ_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CntW'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CntW'(1);
      end
      if (enq_req && full && !deq) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage is not reset. Contents are qualified by count_q.
  always_ff @(posedge in_clk) begin
    if (enq) begin
      insn_mem[wr_ptr_q] <= in_f_insnbits;
      seq_mem[wr_ptr_q]  <= seq_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SEQ_W = 8;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic [31:0] in_f_insnbits;
  logic        in_f_done;
  logic        out_f_stall;
  logic        in_flush;
  logic        in_d_ready;
  logic        out_d_valid;
  logic [31:0] out_d_insnbits;
  logic [7:0]  out_d_seq;
  logic [2:0]  out_count;
  logic        out_overflow;

  fetch_queue #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .in_f_insnbits  (in_f_insnbits),
    .in_f_done      (in_f_done),
    .out_f_stall    (out_f_stall),
    .in_flush       (in_flush),
    .in_d_ready     (in_d_ready),
    .out_d_valid    (out_d_valid),
    .out_d_insnbits (out_d_insnbits),
    .out_d_seq      (out_d_seq),
    .out_count      (out_count),
    .out_overflow   (out_overflow)
  );

  always #5 in_clk = ~in_clk;

  // Reference model: an ordered list of {word, tag}, plus the tag counter.
  typedef struct {
    logic [31:0] insn;
    logic [7:0]  seq;
  } ent_t;

  ent_t        mq[$];
  int unsigned nseq;
  bit          movf;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    nseq = 0;
    movf = 0;
  endtask

  task automatic model_step(input bit done, input logic [31:0] insn, input bit flush,
                            input bit ready);
    bit   deq, full;
    ent_t e;
    if (flush) begin
      mq.delete();
    end else begin
      full = (mq.size() == DEPTH);
      deq  = (mq.size() != 0) && ready;
      if (deq) void'(mq.pop_front());
      if (done) begin
        if (!full || deq) begin
          e.insn = insn;
          e.seq  = 8'(nseq);
          mq.push_back(e);
          nseq = (nseq + 1) % 256;
        end else begin
          movf = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    bit v;
    v = (mq.size() != 0);
    chk({ctx, ":count"}, 32'(out_count), 32'(mq.size()));
    chk({ctx, ":valid"}, 32'(out_d_valid), 32'(v));
    chk({ctx, ":stall"}, 32'(out_f_stall), 32'(mq.size() == DEPTH));
    chk({ctx, ":insn"}, out_d_insnbits, v ? mq[0].insn : 32'h0);
    chk({ctx, ":seq"}, 32'(out_d_seq), v ? 32'(mq[0].seq) : 32'h0);
    chk({ctx, ":ovf"}, 32'(out_overflow), 32'(movf));
  endtask

  task automatic cycle(input string ctx, input bit done, input logic [31:0] insn,
                       input bit flush, input bit ready);
    in_f_done     = done;
    in_f_insnbits = insn;
    in_flush      = flush;
    in_d_ready    = ready;
    @(posedge in_clk);
    model_step(done, insn, flush, ready);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [31:0] words [3];
    int          prev_seq;
    bit          saw_wrap;

    words[0] = 32'h91000421;
    words[1] = 32'h8B020020;
    words[2] = 32'hD65F03C0;

    in_rst_n      = 1'b0;
    in_f_done     = 1'b0;
    in_f_insnbits = '0;
    in_flush      = 1'b0;
    in_d_ready    = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    in_rst_n = 1'b1;

    // Three words with decode stalled, then drain in order.
    for (int i = 0; i < 3; i++) cycle("push3", 1'b1, words[i], 1'b0, 1'b0);
    chk("head_word", out_d_insnbits, 32'h91000421);
    chk("head_seq", 32'(out_d_seq), 32'h0);
    for (int i = 0; i < 3; i++) cycle("drain3", 1'b0, $urandom, 1'b0, 1'b1);
    chk("drained_insn", out_d_insnbits, 32'h0);

    // Fill, overflow drop, then push-with-pop at full.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, $urandom, 1'b0, 1'b0);
    chk("full_stall", 32'(out_f_stall), 32'h1);
    cycle("drop", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("drop_ovf", 32'(out_overflow), 32'h1);
    chk("drop_count", 32'(out_count), 32'h4);
    cycle("full_swap", 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("empty_out", 1'b0, $urandom, 1'b0, 1'b1);
    chk("tail_after_drop", 32'(out_count), 32'h0);

    // Streaming through an empty queue: no bypass, then one per cycle.
    cycle("stream0", 1'b1, $urandom, 1'b0, 1'b1);
    chk("no_bypass_count", 32'(out_count), 32'h1);
    for (int i = 0; i < 6; i++) cycle("stream", 1'b1, $urandom, 1'b0, 1'b1);
    cycle("stream_end", 1'b0, $urandom, 1'b0, 1'b1);

    // Flush with 3 entries while pushing and popping.
    for (int i = 0; i < 3; i++) cycle("preflush", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("flush", 1'b1, $urandom, 1'b1, 1'b1);
    chk("flush_count", 32'(out_count), 32'h0);
    cycle("postflush", 1'b1, $urandom, 1'b0, 1'b0);

    // Tag wrap under continuous drain.
    cycle("wrap_clr", 1'b0, $urandom, 1'b1, 1'b0);
    prev_seq = -1;
    saw_wrap = 0;
    for (int i = 0; i < 260; i++) begin
      cycle("wrap", 1'b1, $urandom, 1'b0, 1'b1);
      if (out_d_valid) begin
        if (prev_seq >= 0) chk("seq_step", 32'(out_d_seq), 32'((prev_seq + 1) % 256));
        if (prev_seq == 255 && out_d_seq == 8'd0) saw_wrap = 1;
        prev_seq = int'(out_d_seq);
      end
    end
    chk("saw_wrap", 32'(saw_wrap), 32'h1);

    // Random traffic, rare flushes.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom,
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-cycle with two entries held.
    cycle("rst_clr", 1'b0, $urandom, 1'b1, 1'b0);
    cycle("rst_pre", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("rst_pre", 1'b1, $urandom, 1'b0, 1'b0);
    chk("rst_pre_count", 32'(out_count), 32'h2);
    in_f_done = 1'b0;
    in_d_ready = 1'b0;
    #1;
    in_rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    check_all("rst_hold");
    @(negedge in_clk);
    in_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle("post_rst", 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
